zwait_serv: RTL and testbench
=============================

Name: zwait_serv

Overview:
- Service end of the Z80 wait mechanism. Watches the per-source wait request flags raised by the Z80 wait generator.
- Captures the stalled Z80 bus cycle, presents it to the AVR-side SPI register file as a pending request, and accepts the AVR's response.
- Then pulses wait_end to release the Z80 and supplies read data while the Z80 finishes the cycle.
- Sits in the fclk domain between the wait generator and the SPI slave registers.

Parameters:
- END_LEN, 4, width of the wait_end pulse in fclk cycles (1..15)
- TIMEOUT, 255, max fclk cycles in HOLD waiting for the wait flags to clear (1..255)
- ABORT_DATA, 8'hFF, data returned to the Z80 on an aborted read

Ports:
- fclk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- waits  in  7  wait request flags from the wait generator; asynchronous to fclk
- zaddr  in  16  Z80 address bus; stable while WAIT is held
- zdin  in  8  Z80 data bus (write data)
- zrd_n  in  1  Z80 read strobe
- zwr_n  in  1  Z80 write strobe
- pend  out  1  request pending to the AVR; also the SPI interrupt status bit
- src  out  3  index of the serviced wait bit, 0..6
- cap_addr  out  16  captured address
- cap_data  out  8  captured write data
- cap_wr  out  1  1 = captured cycle was a write
- resp_data  in  8  AVR response (read data)
- resp_stb  in  1  one-cycle strobe: AVR has finished the request
- abort  in  1  one-cycle strobe: AVR discards the request
- resp_out  out  8  data presented to the Z80 for reads
- resp_oe  out  1  resp_out is valid and is to be driven
- wait_end  out  1  release pulse to the wait generator
- timeout_err  out  1  sticky: wait flags failed to clear
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: pend, src, cap_*, resp_out, resp_oe, wait_end, timeout_err. Armed flag = 0.
- Sync: 2-flop synchronizer on each waits bit. anyw = OR of the synced bits.
- Arming: armed sets when anyw==0 in IDLE. A request is taken only when armed. This blocks re-triggering on a stale flag.
- IDLE -> CAPTURE: when armed & anyw.
- CAPTURE, 1 cycle:
  - latch zaddr, zdin, cap_wr = ~zwr_n;
  - src = lowest set synced bit (bit0 has priority);
  - clear armed; go PENDING.
- PENDING:
  - pend=1. Latency from the waits rising edge to pend=1 is 3 to 4 fclk.
  - resp_stb: resp_out = resp_data (reads only; unchanged for writes), go RELEASE.
  - abort: resp_out = ABORT_DATA (reads only), go RELEASE.
  - Both in the same cycle: abort wins.
  - Strobes in any other state are ignored.
- RELEASE:
  - pend=0; wait_end=1 for exactly END_LEN cycles;
  - resp_oe=1 if cap_wr=0;
  - then go HOLD.
- HOLD:
  - wait_end=0; resp_oe held.
  - Counter runs from 0. anyw==0 -> IDLE.
  - Counter reaches TIMEOUT with anyw still 1 -> set timeout_err, go IDLE.
- IDLE entry: resp_oe=0.
  - cap_* and src hold their values until the next CAPTURE.
  - resp_out holds.
- Multiple waits bits set: a single request is serviced. The wait generator clears all flags on wait_end.
- timeout_err: set and err_clr in the same cycle -> set wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0. wait_end drops even mid-pulse. No request is replayed.
- resp_oe and wait_end are registered outputs, glitch-free.

Test Plan:
- Z80 read at port 16'h00EF, waits=7'b0000001 -> pend=1 within 4 fclk, src=0, cap_addr=16'h00EF, cap_wr=0. Then resp_stb with resp_data=8'h5A -> wait_end high 4 cycles, resp_oe=1, resp_out=8'h5A. Flags cleared -> IDLE, resp_oe=0.
- Write to 16'hF8EF with data 8'h33, waits=7'b0000010 -> src=1, cap_data=8'h33, cap_wr=1. After resp_stb: resp_oe stays 0, wait_end is a 4-cycle pulse.
- waits=7'b0000011 together -> src=0. Single wait_end pulse, one pend assertion only.
- abort during a read -> resp_out=8'hFF. resp_stb and abort in the same cycle -> 8'hFF. resp_stb while in IDLE -> no effect.
- Flags held high after release -> after 255 cycles in HOLD: timeout_err=1, state IDLE, no re-capture until waits==0. err_clr -> timeout_err=0.
- rst asserted during RELEASE -> wait_end=0 and all outputs 0 immediately (asynchronous). After rst release, a new request is serviced normally.

Source files
------------

// File: rtl/zwait_serv.sv
// Service side of the Z80 wait mechanism: captures the stalled bus cycle, hands it to the AVR,
// then releases the Z80 with a wait_end pulse and drives read data until the flags clear.
module zwait_serv #(
    parameter int unsigned END_LEN    = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [7:0]  ABORT_DATA = 8'hFF
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic [6:0]  waits,
    input  logic [15:0] zaddr,
    input  logic [7:0]  zdin,
    input  logic        zrd_n,
    input  logic        zwr_n,
    output logic        pend,
    output logic [2:0]  src,
    output logic [15:0] cap_addr,
    output logic [7:0]  cap_data,
    output logic        cap_wr,
    input  logic [7:0]  resp_data,
    input  logic        resp_stb,
    input  logic        abort,
    output logic [7:0]  resp_out,
    output logic        resp_oe,
    output logic        wait_end,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam logic [7:0] EndLast     = 8'(END_LEN - 1);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StCapture, StPending, StRelease, StHold} state_e;

    state_e      state_q, state_d;
    logic [6:0]  sync1_q, sync2_q;
    logic        armed_q, armed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  src_q, src_d;
    logic [15:0] cap_addr_q, cap_addr_d;
    logic [7:0]  cap_data_q, cap_data_d;
    logic        cap_wr_q, cap_wr_d;
    logic [7:0]  resp_out_q, resp_out_d;
    logic        resp_oe_q, resp_oe_d;
    logic        wait_end_q, wait_end_d;
    logic        timeout_err_q, timeout_err_d;
    logic        anyw;
    logic        err_set;
    logic [2:0]  low_idx;

    assign anyw = |sync2_q;

    // Lowest set bit wins: scan from the top so the last hit is the lowest index.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (sync2_q[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_wr_d   = cap_wr_q;
        resp_out_d = resp_out_q;
        resp_oe_d  = resp_oe_q;
        wait_end_d = wait_end_q;
        err_set    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!anyw) armed_d = 1'b1;
                if (armed_q && anyw) state_d = StCapture;
            end
            StCapture: begin
                cap_addr_d = zaddr;
                cap_data_d = zdin;
                cap_wr_d   = ~zwr_n;
                src_d      = low_idx;
                armed_d    = 1'b0;
                state_d    = StPending;
            end
            StPending: begin
                if (abort || resp_stb) begin
                    if (!cap_wr_q) resp_out_d = abort ? ABORT_DATA : resp_data;
                    state_d    = StRelease;
                    wait_end_d = 1'b1;
                    resp_oe_d  = ~cap_wr_q;
                    cnt_d      = 8'd0;
                end
            end
            StRelease: begin
                if (cnt_q == EndLast) begin
                    state_d    = StHold;
                    wait_end_d = 1'b0;
                    cnt_d      = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (!anyw) begin
                    state_d   = StIdle;
                    resp_oe_d = 1'b0;
                end else if (cnt_q == TimeoutLast) begin
                    err_set   = 1'b1;
                    state_d   = StIdle;
                    resp_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        timeout_err_d = err_set | (timeout_err_q & ~err_clr);
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            sync1_q       <= 7'd0;
            sync2_q       <= 7'd0;
            armed_q       <= 1'b0;
            cnt_q         <= 8'd0;
            src_q         <= 3'd0;
            cap_addr_q    <= 16'd0;
            cap_data_q    <= 8'd0;
            cap_wr_q      <= 1'b0;
            resp_out_q    <= 8'd0;
            resp_oe_q     <= 1'b0;
            wait_end_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= waits;
            sync2_q       <= sync1_q;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            src_q         <= src_d;
            cap_addr_q    <= cap_addr_d;
            cap_data_q    <= cap_data_d;
            cap_wr_q      <= cap_wr_d;
            resp_out_q    <= resp_out_d;
            resp_oe_q     <= resp_oe_d;
            wait_end_q    <= wait_end_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pend        = (state_q == StPending);
    assign src         = src_q;
    assign cap_addr    = cap_addr_q;
    assign cap_data    = cap_data_q;
    assign cap_wr      = cap_wr_q;
    assign resp_out    = resp_out_q;
    assign resp_oe     = resp_oe_q;
    assign wait_end    = wait_end_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_zwait_serv.sv
// Bench for zwait_serv: directed scenarios plus random transactions checked against a
// transaction-level model of what the Z80 and AVR should observe.
module tb_zwait_serv;

    localparam int unsigned END_LEN    = 4;
    localparam int unsigned TIMEOUT    = 255;
    localparam logic [7:0]  ABORT_DATA = 8'hFF;

    logic        fclk = 1'b0;
    logic        rst;
    logic [6:0]  waits;
    logic [15:0] zaddr;
    logic [7:0]  zdin;
    logic        zrd_n, zwr_n;
    logic        pend;
    logic [2:0]  src;
    logic [15:0] cap_addr;
    logic [7:0]  cap_data;
    logic        cap_wr;
    logic [7:0]  resp_data;
    logic        resp_stb, abort;
    logic [7:0]  resp_out;
    logic        resp_oe, wait_end, timeout_err, err_clr;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_out;

    zwait_serv #(
        .END_LEN   (END_LEN),
        .TIMEOUT   (TIMEOUT),
        .ABORT_DATA(ABORT_DATA)
    ) dut (
        .fclk       (fclk),
        .rst        (rst),
        .waits      (waits),
        .zaddr      (zaddr),
        .zdin       (zdin),
        .zrd_n      (zrd_n),
        .zwr_n      (zwr_n),
        .pend       (pend),
        .src        (src),
        .cap_addr   (cap_addr),
        .cap_data   (cap_data),
        .cap_wr     (cap_wr),
        .resp_data  (resp_data),
        .resp_stb   (resp_stb),
        .abort      (abort),
        .resp_out   (resp_out),
        .resp_oe    (resp_oe),
        .wait_end   (wait_end),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 fclk = ~fclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pend"}, 32'(pend), 0);
        check_eq({tag, "_src"}, 32'(src), 0);
        check_eq({tag, "_addr"}, 32'(cap_addr), 0);
        check_eq({tag, "_data"}, 32'(cap_data), 0);
        check_eq({tag, "_wr"}, 32'(cap_wr), 0);
        check_eq({tag, "_out"}, 32'(resp_out), 0);
        check_eq({tag, "_oe"}, 32'(resp_oe), 0);
        check_eq({tag, "_we"}, 32'(wait_end), 0);
        check_eq({tag, "_err"}, 32'(timeout_err), 0);
    endtask

    // mode: 0 = resp_stb, 1 = abort, 2 = both together. hold keeps the flags up after release.
    task automatic run_txn(input logic [6:0] w, input logic [15:0] a, input logic [7:0] d,
                           input bit wr, input int mode, input int dly, input logic [7:0] rdat,
                           input bit hold);
        int n;
        int lowest;
        lowest = -1;
        for (int i = 0; i < 7; i++) if (w[i] && lowest < 0) lowest = i;

        zaddr = a; zdin = d; zwr_n = !wr; zrd_n = wr; waits = w;
        n = 0;
        while (!pend && n < 10) begin tick(); n++; end
        check_eq("pend_latency_ok", 32'(n >= 3 && n <= 4), 1);
        check_eq("src", 32'(src), 32'(lowest));
        check_eq("cap_addr", 32'(cap_addr), 32'(a));
        check_eq("cap_wr", 32'(cap_wr), 32'(wr));
        if (wr) check_eq("cap_data", 32'(cap_data), 32'(d));

        repeat (dly) tick();
        check_eq("pend_held", 32'(pend), 1);
        check_eq("we_before_resp", 32'(wait_end), 0);

        resp_data = rdat;
        resp_stb  = (mode != 1);
        abort     = (mode != 0);
        tick();
        resp_stb = 1'b0; abort = 1'b0;
        if (!wr) exp_out = (mode == 0) ? rdat : ABORT_DATA;
        check_eq("pend_dropped", 32'(pend), 0);
        check_eq("wait_end_on", 32'(wait_end), 1);
        check_eq("resp_oe_rel", 32'(resp_oe), 32'(!wr));
        check_eq("resp_out_rel", 32'(resp_out), 32'(exp_out));

        if (!hold) waits = 7'd0;
        n = 0;
        while (wait_end && n < 40) begin n++; tick(); end
        check_eq("wait_end_len", 32'(n), END_LEN);
        check_eq("resp_oe_hold", 32'(resp_oe), 32'(!wr));

        if (!hold) begin
            repeat (3) tick();
            check_eq("resp_oe_idle", 32'(resp_oe), 0);
            check_eq("resp_out_kept", 32'(resp_out), 32'(exp_out));
            check_eq("cap_addr_kept", 32'(cap_addr), 32'(a));
            check_eq("src_kept", 32'(src), 32'(lowest));
            check_eq("no_repend", 32'(pend), 0);
            repeat (2) tick();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; waits = 7'd0; zaddr = 16'd0; zdin = 8'd0; zrd_n = 1'b1; zwr_n = 1'b1;
        resp_data = 8'd0; resp_stb = 1'b0; abort = 1'b0; err_clr = 1'b0;
        exp_out = 8'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Directed scenarios.
        run_txn(7'b0000001, 16'h00EF, 8'h00, 1'b0, 0, 2, 8'h5A, 1'b0);
        run_txn(7'b0000010, 16'hF8EF, 8'h33, 1'b1, 0, 1, 8'hC3, 1'b0);
        run_txn(7'b0000011, 16'h1234, 8'h00, 1'b0, 0, 0, 8'h77, 1'b0);
        run_txn(7'b0100000, 16'h4321, 8'h00, 1'b0, 1, 3, 8'h12, 1'b0);
        run_txn(7'b1000000, 16'hABCD, 8'h00, 1'b0, 2, 1, 8'h34, 1'b0);

        // Response strobes outside PENDING must not disturb anything.
        resp_data = 8'h99; resp_stb = 1'b1; tick();
        resp_stb = 1'b0; abort = 1'b1; tick();
        abort = 1'b0; tick();
        check_eq("idle_stb_out", 32'(resp_out), 32'(exp_out));
        check_eq("idle_stb_we", 32'(wait_end), 0);
        check_eq("idle_stb_pend", 32'(pend), 0);

        // Flags stuck high: timeout. err_clr held meanwhile so the set-over-clear rule is exercised.
        run_txn(7'b0000100, 16'h0F0F, 8'h00, 1'b0, 0, 0, 8'hE1, 1'b1);
        err_clr = 1'b1;
        n = 0;
        while (!timeout_err && n < 400) begin tick(); n++; end
        err_clr = 1'b0;
        check_eq("timeout_cycles_ok", 32'(n >= TIMEOUT && n <= TIMEOUT + 1), 1);
        check_eq("timeout_err_set", 32'(timeout_err), 1);
        tick();
        check_eq("timeout_oe_off", 32'(resp_oe), 0);
        repeat (10) tick();
        check_eq("no_recapture", 32'(pend), 0);
        check_eq("err_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_eq("err_cleared", 32'(timeout_err), 0);
        waits = 7'd0;
        repeat (4) tick();

        // Reset in the middle of the release pulse.
        zaddr = 16'h5555; zrd_n = 1'b0; zwr_n = 1'b1; waits = 7'b0001000;
        n = 0;
        while (!pend && n < 10) begin tick(); n++; end
        check_eq("rst_pre_pend", 32'(pend), 1);
        resp_data = 8'h66; resp_stb = 1'b1; tick(); resp_stb = 1'b0;
        tick();
        check_eq("rst_pre_we", 32'(wait_end), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        waits = 7'd0; exp_out = 8'd0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check_eq("post_rst_idle", 32'(pend), 0);
        run_txn(7'b0010000, 16'h2468, 8'h00, 1'b0, 0, 1, 8'hA5, 1'b0);

        // Random transactions.
        for (int t = 0; t < 30; t++) begin
            run_txn(7'($urandom_range(1, 127)), 16'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), 8'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
